// File: rtl/arb_robinfair_pkg.sv
// Shared defaults for the round-robin fair arbiter.
package arb_robinfair_pkg;
  localparam int DEF_INDEX_WIDTH    = 3;
  localparam int DEF_NUM_CANDIDATES = 5;
endpackage

// File: rtl/arb_robinfair_next_finder.sv
// Combinational search for the first requester strictly after a pointer,
// wrapping modulo NUM_CANDIDATES.
import arb_robinfair_pkg::*;

module arb_robinfair_next_finder #(
  parameter int INDEX_WIDTH    = DEF_INDEX_WIDTH,
  parameter int NUM_CANDIDATES = DEF_NUM_CANDIDATES
) (
  input  logic [INDEX_WIDTH-1:0]    pointer,
  input  logic [NUM_CANDIDATES-1:0] requests,
  output logic [INDEX_WIDTH-1:0]    index,
  output logic                      found
);
  localparam int SCAN_LEN = NUM_CANDIDATES - 1;

  int unsigned j;

  // Nearest offset wins: once found is set, later (farther) hits are ignored.
  always_comb begin
    found = 1'b0;
    index = '0;
    j     = 0;
    for (int off = 1; off <= SCAN_LEN; off++) begin
      j = (int'(pointer) + off) % NUM_CANDIDATES;
      if (!found && requests[j]) begin
        found = 1'b1;
        index = INDEX_WIDTH'(j);
      end
    end
  end
endmodule

// File: rtl/arb_robinfair.sv
// Round-robin fair arbiter: registered current grant plus combinational
// round-robin successor; advances on ce or when current stops requesting.
import arb_robinfair_pkg::*;

module arb_robinfair #(
  parameter int INDEX_WIDTH    = DEF_INDEX_WIDTH,
  parameter int NUM_CANDIDATES = DEF_NUM_CANDIDATES
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ce,
  input  logic [NUM_CANDIDATES-1:0] candidates,
  output logic [INDEX_WIDTH-1:0]    current,
  output logic [INDEX_WIDTH-1:0]    next
);
  logic [INDEX_WIDTH-1:0] found_index;
  logic                   found;
  logic                   advance;

  arb_robinfair_next_finder #(
    .INDEX_WIDTH   (INDEX_WIDTH),
    .NUM_CANDIDATES(NUM_CANDIDATES)
  ) u_finder (
    .pointer (current),
    .requests(candidates),
    .index   (found_index),
    .found   (found)
  );

  // No other requester: stay put, whether or not current itself requests.
  assign next    = found ? found_index : current;
  assign advance = ce || !candidates[current];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          current <= '0;
    else if (advance) current <= next;
  end
endmodule

// File: tb/tb_arb_robinfair.sv
// Scoreboard bench: stimulus pushes model expectations, a monitor pops and
// compares them against the DUT each cycle.
module tb_arb_robinfair;
  localparam int N  = 5;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          ce;
  logic [N-1:0]  candidates;
  logic [IW-1:0] current;
  logic [IW-1:0] next;

  typedef struct { int cur; int nxt; string tag; } exp_t;
  exp_t exp_q[$];
  event sample_ev;
  int   n_pass = 0;
  int   n_total = 0;
  int   model_cur = 0;

  arb_robinfair #(.INDEX_WIDTH(IW), .NUM_CANDIDATES(N)) dut (
    .clk(clk), .rst(rst), .ce(ce), .candidates(candidates),
    .current(current), .next(next)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int expv);
    n_total++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, expv);
  endtask

  // Closest requester above cur, else lowest requester below cur, else cur.
  function automatic int ref_next(input int cur, input logic [N-1:0] c);
    int after = -1;
    int wrap  = -1;
    for (int i = 0; i < N; i++)
      if (c[i]) begin
        if (i > cur && after < 0) after = i;
        if (i < cur && wrap  < 0) wrap  = i;
      end
    return (after >= 0) ? after : ((wrap >= 0) ? wrap : cur);
  endfunction

  // Called at a falling edge; returns at the following falling edge.
  task automatic step(input logic c_e, input logic [N-1:0] cand, input string tag);
    exp_t e;
    ce = c_e;
    candidates = cand;
    e.cur = model_cur;
    e.nxt = ref_next(model_cur, cand);
    e.tag = tag;
    exp_q.push_back(e);
    -> sample_ev;
    if (c_e || !cand[model_cur]) model_cur = e.nxt;
    @(negedge clk);
  endtask

  // Mid-cycle asynchronous reset, released at the next falling edge.
  task automatic mid_reset(input string tag);
    #3 rst = 1'b1;
    #1;
    chk({tag, "_cur"}, int'(current), 0);
    chk({tag, "_nxt"}, int'(next), ref_next(0, candidates));
    @(negedge clk);
    rst = 1'b0;
    model_cur = 0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(sample_ev);
      #1;
      if (exp_q.size() == 0) begin
        chk("queue_empty", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk({e.tag, "_cur"}, int'(current), e.cur);
        chk({e.tag, "_nxt"}, int'(next), e.nxt);
        chk({e.tag, "_range"}, int'(current < N), 1);
      end
    end
  end

  initial begin : stim
    logic [N-1:0] rc;
    rst = 1'b1;
    ce = 1'b0;
    candidates = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_cur", int'(current), 0);
    chk("reset_nxt", int'(next), 0);
    rst = 1'b0;
    model_cur = 0;

    step(1'b0, 5'b00000, "idle");
    step(1'b0, 5'b00000, "idle_hold");
    step(1'b0, 5'b01010, "auto_adv");
    step(1'b1, 5'b01010, "ce_adv");
    step(1'b0, 5'b01010, "wrap_view");
    mid_reset("async_rst");

    for (int i = 0; i < 5; i++) step(1'b1, 5'b10001, "wrap5");
    for (int i = 0; i < 4; i++) step(1'b1, 5'b00100, "single");
    step(1'b1, 5'b00001, "only_self");
    step(1'b1, 5'b00001, "only_self2");
    step(1'b0, 5'b00000, "none_hold");

    for (int i = 0; i < 400; i++) begin
      rc = N'($urandom);
      if ($urandom_range(0, 7) == 0) rc = '0;
      step(1'($urandom_range(0, 1)), rc, "rand");
      if ($urandom_range(0, 49) == 0) mid_reset("rand_rst");
    end

    #5;
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: timeout reached, expected finish");
    $fatal(1);
  end
endmodule

// File: doc/arb_robinfair.md
Name: arb_robinfair

Overview:
- Round-robin fair arbiter. Holds a registered "current" grant index and combinationally computes the "next" candidate in round-robin order after current.
- Advances to the next candidate when the consumer asserts ce, or automatically when the current index is no longer requesting.
- Used by multi-source request/response fabrics to pick the source served next.

Parameters:
- INDEX_WIDTH, default 3: width of the current/next index outputs; must satisfy 2^INDEX_WIDTH >= NUM_CANDIDATES.
- NUM_CANDIDATES, default 5: number of request lines. Indices run 0..NUM_CANDIDATES-1.

Ports:
- clk, input, 1: sole clock; all state updates on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- ce, input, 1: advance enable; current is consumed, so move to next.
- candidates, input, NUM_CANDIDATES: request vector; bit i set means index i requests.
- current, output, INDEX_WIDTH: registered currently selected index.
- next, output, INDEX_WIDTH: combinational round-robin successor of current.

Behaviour:
- Reset: while rst=1, current=0 asynchronously. next then follows its combinational rule, e.g. next=0 when candidates=0.
- next, combinational, no latency:
  - Scan indices (current+1), (current+2), ..., (current+NUM_CANDIDATES-1), each taken modulo NUM_CANDIDATES. The modulo base is NUM_CANDIDATES, not 2^INDEX_WIDTH.
  - next = the first scanned index whose candidates bit is 1.
  - If no scanned index requests, next = current. This holds whether or not candidates[current] is set.
- current update at each rising clk:
  - If ce=1, or candidates[current]=0: current <= next.
  - Otherwise current holds.
- Consequences:
  - A stale current (its request dropped) moves to the next requester one cycle later, even with ce=0.
  - With no requests at all, current holds, because next=current.
  - A single requester at index k: current reaches k and stays there; next=k.
  - ce=1 with only current requesting: current stays.
- Wrap-around: from index NUM_CANDIDATES-1 the scan continues at 0.
- Fairness: each ce grants the closest requester strictly after current in cyclic order, so every persistent requester is reached within NUM_CANDIDATES-1 advances.
- Candidates may change on any cycle. next reflects the new value immediately, and current updates at the next edge per the rule above.
- Reset asserted mid-operation forces current=0 immediately, regardless of ce or candidates.
- current never holds a value >= NUM_CANDIDATES.

Decomposition:
- No shared package typedefs required. A localparam for the scan length (NUM_CANDIDATES-1) lives inside the module.
- One natural sub-module, arb_robinfair_next_finder:
  - Purely combinational.
  - Inputs: pointer, request vector.
  - Output: first requester strictly after the pointer cyclically, plus a found flag.
  - The top module holds the current register and the advance logic.

Test Plan:
- Reset, candidates=00000, ce=0 -> after release and one edge: current=0, next=0.
- From current=0, candidates=01010, ce=0 -> after one edge: current=1 (auto-advance, bit0 idle), next=3.
- Then ce=1, candidates=01010 -> after one edge: current=3, next=1 (wrap past 4 to 1).
- candidates=10001, ce=1 held, start current=0 -> current cycles 0,4,0,4. Checks wrap at NUM_CANDIDATES=5, not 8.
- Single requester: candidates=00100, ce=1 -> current settles at 2 and holds; next=2.
- Assert rst mid-run with current=3 -> current=0 immediately, without waiting for a clock edge.
